// File: rtl/later_spad_read_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : later_spad_read_seq_pkg
// Brief    : Shared PE spad constants: widths, clear-sweep length and the
//            field layout of a 12-bit spad word (data [11:4], count [3:0]).
// Revision : 1.0 - initial release
// ============================================================================
package later_spad_read_seq_pkg;

    localparam int SPAD_ADDR_W       = 7;
    localparam int SPAD_DATA_W       = 8;
    localparam int SPAD_CNT_W        = 4;
    localparam int SPAD_WORD_W       = SPAD_DATA_W + SPAD_CNT_W;
    localparam int SPAD_CLEAR_CYCLES = 100;

    // Field slices of a spad word
    localparam int SPAD_DATA_MSB     = SPAD_WORD_W - 1;
    localparam int SPAD_DATA_LSB     = SPAD_CNT_W;
    localparam int SPAD_CNT_MSB      = SPAD_CNT_W - 1;
    localparam int SPAD_CNT_LSB      = 0;

endpackage : later_spad_read_seq_pkg
`default_nettype wire

// File: rtl/later_spad_read_seq.sv
`default_nettype none
// ============================================================================
// Module   : later_spad_read_seq
// Brief    : Fetches one CSC column from the later data spad and streams its
//            (data, row) elements to the PE MAC over valid/ready. Start is
//            held off until the spad's post-reset clear sweep has finished.
// Revision : 1.0 - initial release
// ============================================================================
module later_spad_read_seq
    import later_spad_read_seq_pkg::*;
#(
    parameter int ADDR_W      = SPAD_ADDR_W,
    parameter int DATA_W      = SPAD_DATA_W,
    parameter int CNT_W       = SPAD_CNT_W,
    parameter int INIT_CYCLES = SPAD_CLEAR_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   start_ready,
    input  logic [ADDR_W-1:0]      col_start,
    input  logic [ADDR_W-1:0]      col_end,
    output logic [ADDR_W-1:0]      spad_read_idx,
    output logic                   spad_read_idx_en,
    output logic                   spad_read_en,
    output logic                   spad_index_inc,
    input  logic [SPAD_WORD_W-1:0] spad_data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_last,
    output logic                   done,
    output logic                   busy,
    output logic                   init_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEEK   = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_STREAM = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_remaining;
    logic [INIT_W-1:0]   r_init_cnt;
    logic [ADDR_W-1:0]   w_span;

    // Column length; a wrapped range simply becomes a modulo length
    assign w_span         = col_end - col_start;
    assign start_ready    = (r_state == S_IDLE) && init_done;
    assign busy           = (r_state != S_IDLE);
    // The column pointer advances exactly when the MAC takes an element
    assign spad_index_inc = out_valid && out_ready;

    // Clear-sweep timer: init_done rises once INIT_CYCLES cycles have elapsed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_init_cnt <= '0;
            init_done  <= 1'b0;
        end else if (!init_done) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                init_done <= 1'b1;
            end
        end
    end

    // Column fetch FSM; every spad control and stream field is registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_remaining      <= '0;
            spad_read_idx    <= '0;
            spad_read_idx_en <= 1'b0;
            spad_read_en     <= 1'b0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            out_count        <= '0;
            out_last         <= 1'b0;
            done             <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && start_ready) begin
                        spad_read_idx <= col_start;
                        r_remaining   <= w_span;
                        if (w_span == '0) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                        end else begin
                            r_state          <= S_SEEK;
                            spad_read_idx_en <= 1'b1;
                        end
                    end
                end
                S_SEEK: begin
                    spad_read_idx_en <= 1'b0;
                    spad_read_en     <= 1'b1;
                    r_state          <= S_ISSUE;
                end
                S_ISSUE: begin
                    spad_read_en <= 1'b0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    // Spad word is valid now, one cycle after the read strobe
                    out_data  <= spad_data_out[SPAD_DATA_MSB:SPAD_DATA_LSB];
                    out_count <= spad_data_out[SPAD_CNT_MSB:SPAD_CNT_LSB];
                    out_last  <= (r_remaining == ADDR_W'(1));
                    out_valid <= 1'b1;
                    r_state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == ADDR_W'(1)) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                        end else begin
                            r_state      <= S_ISSUE;
                            spad_read_en <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : later_spad_read_seq
`default_nettype wire

// File: tb/tb_later_spad_read_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_later_spad_read_seq
// Brief    : Directed self-checking bench for later_spad_read_seq with a
//            behavioural 1-cycle-latency spad model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_later_spad_read_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_ready;
    logic [6:0]  col_start = '0;
    logic [6:0]  col_end = '0;
    logic [6:0]  spad_read_idx;
    logic        spad_read_idx_en;
    logic        spad_read_en;
    logic        spad_index_inc;
    logic [11:0] spad_data_out = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [3:0]  out_count;
    logic        out_last;
    logic        done;
    logic        busy;
    logic        init_done;

    int tests = 0;
    int fails = 0;

    logic [11:0] mem [0:127];
    logic [6:0]  ptr = '0;

    // Expected beats of column 3..6
    logic [7:0]  exp_data [0:2];
    logic [3:0]  exp_cnt  [0:2];

    later_spad_read_seq dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .start_ready      (start_ready),
        .col_start        (col_start),
        .col_end          (col_end),
        .spad_read_idx    (spad_read_idx),
        .spad_read_idx_en (spad_read_idx_en),
        .spad_read_en     (spad_read_en),
        .spad_index_inc   (spad_index_inc),
        .spad_data_out    (spad_data_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_count        (out_count),
        .out_last         (out_last),
        .done             (done),
        .busy             (busy),
        .init_done        (init_done)
    );

    always #5 clock = ~clock;

    // Spad model: column pointer plus registered read port
    always @(posedge clock) begin
        if (spad_read_idx_en)    ptr <= spad_read_idx;
        else if (spad_index_inc) ptr <= ptr + 7'd1;
        if (spad_read_en)        spad_data_out <= mem[ptr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All outputs zero during reset; start_ready low for cycles 0..99, accept at 100
    task automatic test_reset();
        int early_ready;
        start = 1'b1; col_start = 7'd10; col_end = 7'd10; reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        tests++;
        if ({start_ready, spad_read_idx, spad_read_idx_en, spad_read_en, spad_index_inc, out_valid,
             out_data, out_count, out_last, done, busy, init_done} !== '0) begin
            fails++; $display("FAIL reset_outputs: got nonzero output, expected all 0");
        end
        @(negedge clock); reset = 1'b0;
        early_ready = 0;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (start_ready !== 1'b0 || busy !== 1'b0) early_ready++;
            @(negedge clock);
        end
        #1;
        tests++;
        if (early_ready !== 0) begin
            fails++; $display("FAIL init_window: start_ready high in %0d cycles, expected 0", early_ready);
        end
        tests++;
        if (start_ready !== 1'b1 || init_done !== 1'b1) begin
            fails++; $display("FAIL init_cycle100: start_ready=%0b init_done=%0b, expected 1/1", start_ready, init_done);
        end
        @(negedge clock); start = 1'b0; #1;
        tests++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            fails++; $display("FAIL first_accept: busy=%0b done=%0b, expected 1/1", busy, done);
        end
        repeat (2) @(negedge clock);
    endtask

    // Column 3..6 with out_ready always high
    task automatic test_stream();
        int k = 0, first_t = -1, last_t = -1, done_t = -1, done_cnt = 0;
        @(negedge clock);
        col_start = 7'd3; col_end = 7'd6; start = 1'b1; out_ready = 1'b1; #1;
        tests++;
        if (start_ready !== 1'b1) begin
            fails++; $display("FAIL stream_ready: start_ready=%0b, expected 1", start_ready);
        end
        for (int t = 1; t <= 20; t++) begin
            @(negedge clock); start = 1'b0; #1;
            if (t == 1) begin
                tests++;
                if (spad_read_idx_en !== 1'b1 || spad_read_idx !== 7'd3) begin
                    fails++; $display("FAIL seek: idx_en=%0b idx=%0d, expected 1/3", spad_read_idx_en, spad_read_idx);
                end
            end
            if (out_valid && first_t < 0) first_t = t;
            if (out_valid && out_ready && k < 3) begin
                tests++;
                if (out_data !== exp_data[k] || out_count !== exp_cnt[k] || out_last !== (k == 2)
                    || spad_index_inc !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_beat%0d: data=%h cnt=%0d last=%0b inc=%0b, expected %h/%0d/%0b/1",
                             k, out_data, out_count, out_last, spad_index_inc, exp_data[k], exp_cnt[k], (k == 2));
                end
                k++; last_t = t;
            end
            if (done) begin done_cnt++; done_t = t; end
        end
        tests++;
        if (first_t !== 4) begin
            fails++; $display("FAIL stream_latency: first valid at %0d, expected 4", first_t);
        end
        tests++;
        if (k !== 3 || done_cnt !== 1 || done_t !== last_t + 1) begin
            fails++; $display("FAIL stream_done: beats=%0d dones=%0d done_t=%0d, expected 3/1/%0d", k, done_cnt, done_t, last_t + 1);
        end
    endtask

    // Same column, beat 2 held off for 5 cycles
    task automatic test_backpressure();
        int k = 0, stall = 0, incs = 0, bad_hold = 0;
        @(negedge clock);
        col_start = 7'd3; col_end = 7'd6; start = 1'b1; out_ready = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clock); start = 1'b0;
            out_ready = !(out_valid && k == 1 && stall < 5);
            #1;
            if (!out_ready) begin
                stall++;
                if (out_data !== 8'hF9 || out_count !== 4'd4 || spad_index_inc !== 1'b0) bad_hold++;
            end
            if (spad_index_inc) incs++;
            if (out_valid && out_ready) k++;
        end
        out_ready = 1'b1;
        tests++;
        if (stall !== 5 || bad_hold !== 0) begin
            fails++; $display("FAIL bp_hold: stalls=%0d unstable=%0d, expected 5/0", stall, bad_hold);
        end
        tests++;
        if (incs !== 3 || k !== 3) begin
            fails++; $display("FAIL bp_inc: index_inc=%0d beats=%0d, expected 3/3", incs, k);
        end
    endtask

    // Empty column: done only, no reads, no stream
    task automatic test_empty();
        int done_t = -1, done_cnt = 0, stray = 0;
        @(negedge clock);
        col_start = 7'd10; col_end = 7'd10; start = 1'b1; out_ready = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clock); start = 1'b0; #1;
            if (out_valid || spad_read_en || spad_read_idx_en) stray++;
            if (done) begin done_cnt++; done_t = t; end
        end
        tests++;
        if (stray !== 0 || done_cnt !== 1 || done_t < 1 || done_t > 2 || busy !== 1'b0) begin
            fails++; $display("FAIL empty_col: stray=%0d dones=%0d done_t=%0d busy=%0b, expected 0/1/1..2/0",
                              stray, done_cnt, done_t, busy);
        end
    endtask

    // Reset while beat 2 is on the stream
    task automatic test_reset_mid();
        int k = 0, reached = 0, dones = 0;
        @(negedge clock);
        col_start = 7'd3; col_end = 7'd6; start = 1'b1; out_ready = 1'b0;
        for (int t = 1; t <= 20 && !reached; t++) begin
            @(negedge clock); start = 1'b0;
            out_ready = !(out_valid && k == 1);
            #1;
            if (out_valid && k == 1) reached = 1;
            else if (out_valid && out_ready) k++;
        end
        tests++;
        if (reached !== 1) begin
            fails++; $display("FAIL rmid_reach: beat2 seen=%0d, expected 1", reached);
        end
        reset = 1'b1; #1;
        tests++;
        if ({start_ready, spad_read_idx, spad_read_idx_en, spad_read_en, spad_index_inc, out_valid,
             out_data, out_count, out_last, done, busy, init_done} !== '0) begin
            fails++; $display("FAIL rmid_outputs: out_valid=%0b busy=%0b init_done=%0b data=%h, expected all 0",
                              out_valid, busy, init_done, out_data);
        end
        for (int t = 0; t < 3; t++) begin
            @(negedge clock); #1; if (done) dones++;
        end
        reset = 1'b0; out_ready = 1'b1;
        for (int t = 0; t < 120 && !init_done; t++) begin
            @(negedge clock); #1; if (done) dones++;
        end
        tests++;
        if (dones !== 0 || init_done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL rmid_recover: dones=%0d init_done=%0b busy=%0b, expected 0/1/0", dones, init_done, busy);
        end
    endtask

    // Starts while busy are dropped; the next column needs a fresh start after done
    task automatic test_back_to_back();
        int k = 0, found = 0, bad_beat = 0, b2 = 0;
        @(negedge clock);
        col_start = 7'd3; col_end = 7'd6; start = 1'b1; out_ready = 1'b1;
        for (int t = 1; t <= 30 && !found; t++) begin
            @(negedge clock); start = 1'b0;
            if (t == 2 || t == 5) begin col_start = 7'd0; col_end = 7'd2; start = 1'b1; end
            #1;
            if (t == 2) begin
                tests++;
                if (start_ready !== 1'b0 || busy !== 1'b1) begin
                    fails++; $display("FAIL b2b_busy_ready: start_ready=%0b busy=%0b, expected 0/1", start_ready, busy);
                end
            end
            if (out_valid && out_ready) begin
                if (k > 2 || out_data !== exp_data[k] || out_count !== exp_cnt[k]) bad_beat++;
                k++;
            end
            if (done) found = 1;
        end
        tests++;
        if (found !== 1 || k !== 3 || bad_beat !== 0) begin
            fails++; $display("FAIL b2b_first: done=%0d beats=%0d bad=%0d, expected 1/3/0", found, k, bad_beat);
        end
        // Now in FIN: a start here must wait for IDLE
        col_start = 7'd7; col_end = 7'd8; start = 1'b1; #1;
        tests++;
        if (start_ready !== 1'b0) begin
            fails++; $display("FAIL b2b_fin_ready: start_ready=%0b, expected 0", start_ready);
        end
        @(negedge clock); #1;
        tests++;
        if (start_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_idle_ready: start_ready=%0b, expected 1", start_ready);
        end
        found = 0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clock); start = 1'b0; #1;
            if (out_valid && out_ready) begin
                b2++;
                tests++;
                if (out_data !== 8'h12 || out_count !== 4'd3 || out_last !== 1'b1) begin
                    fails++; $display("FAIL b2b_second_beat: data=%h cnt=%0d last=%0b, expected 12/3/1",
                                      out_data, out_count, out_last);
                end
            end
            if (done) found++;
        end
        tests++;
        if (b2 !== 1 || found !== 1) begin
            fails++; $display("FAIL b2b_second_done: beats=%0d dones=%0d, expected 1/1", b2, found);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 12'(i * 7 + 12'h300);
        mem[0] = 12'hA1A; mem[1] = 12'hB2B;
        mem[3] = 12'h051; mem[4] = 12'hF94; mem[5] = 12'h7FF;
        mem[7] = 12'h123;
        exp_data[0] = 8'h05; exp_data[1] = 8'hF9; exp_data[2] = 8'h7F;
        exp_cnt[0]  = 4'd1;  exp_cnt[1]  = 4'd4;  exp_cnt[2]  = 4'd15;

        test_reset();
        test_stream();
        test_backpressure();
        test_empty();
        test_reset_mid();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_later_spad_read_seq
`default_nettype wire
